alu_seq: RTL and testbench

//  Registered, parametrised ALU for the simple CPU datapath; next generation of the 8-bit combinational ALU.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle arithmetic/logic/shift ops
// and an iterative shift-add multiply. Only one operation is in flight at a time.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpNot = 3'd4;
  localparam logic [2:0] OpXor = 3'd5;
  localparam logic [2:0] OpShl = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  // Z and N are derived from val when the result is registered
  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             c;
    logic             v;
  } result_t;

  state_t  state, stateNext;
  logic    accept, retire, mulLast, resultLand;
  result_t aluRes, mulRes, landRes;

  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] mulAcc, mulCand, mulAccNext;
  logic [WIDTH-1:0]   mulPlier;
  logic [SHW-1:0]     mulCnt;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  assign sum  = {1'b0, reg1} + {1'b0, reg2};
  assign diff = {1'b0, reg1} - {1'b0, reg2};

  // Log-stage barrel shift on W+1 bits; bit W of the last stage is the final
  // bit pushed out of the result, i.e. A[W-s], and stays 0 for s=0.
  logic [SHW:0][WIDTH:0] shStage;
  assign shStage[0] = {1'b0, reg1};
  for (genvar k = 0; k < SHW; k++) begin : gShift
    assign shStage[k+1] = reg2[k] ? (shStage[k] << (2**k)) : shStage[k];
  end

  always_comb begin
    aluRes = '0;
    case (mode)
      OpAdd: begin
        aluRes.val = sum[WIDTH-1:0];
        aluRes.c   = sum[WIDTH];
        aluRes.v   = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
      end
      OpSub: begin
        aluRes.val = diff[WIDTH-1:0];
        aluRes.c   = diff[WIDTH];
        aluRes.v   = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);
      end
      OpAnd:   aluRes.val = reg1 & reg2;
      OpOr:    aluRes.val = reg1 | reg2;
      OpNot:   aluRes.val = ~reg1;
      OpXor:   aluRes.val = reg1 ^ reg2;
      OpShl: begin
        aluRes.val = shStage[SHW][WIDTH-1:0];
        aluRes.c   = shStage[SHW][WIDTH];
      end
      default: aluRes = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply: one multiplier bit per cycle, WIDTH cycles
  // ---------------------------------------------------------------------------
  assign mulAccNext = mulAcc + (mulPlier[0] ? mulCand : '0);
  assign mulLast    = (state == MUL) && (mulCnt == CntLast);

  always_comb begin
    mulRes     = '0;
    mulRes.val = mulAccNext[WIDTH-1:0];
    mulRes.c   = |mulAccNext[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mulAcc   <= '0;
      mulCand  <= '0;
      mulPlier <= '0;
      mulCnt   <= '0;
    end else if (accept) begin
      mulAcc   <= '0;
      mulCand  <= {{WIDTH{1'b0}}, reg1};
      mulPlier <= reg2;
      mulCnt   <= '0;
    end else if (state == MUL) begin
      mulAcc   <= mulAccNext;
      mulCand  <= mulCand << 1;
      mulPlier <= mulPlier >> 1;
      mulCnt   <= mulCnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && mode == OpMul) stateNext = MUL;
      MUL:     if (mulLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  end

  assign accept     = in_valid && in_ready;
  assign retire     = out_valid && out_ready;
  assign resultLand = (accept && mode != OpMul) || mulLast;
  assign landRes    = mulLast ? mulRes : aluRes;

  // ---------------------------------------------------------------------------
  // Result register: held until retired, a new result may land on the retire edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      out_valid <= 1'b0;
    end else if (resultLand) begin
      out       <= landRes.val;
      flag_z    <= (landRes.val == '0);
      flag_c    <= landRes.c;
      flag_n    <= landRes.val[WIDTH-1];
      flag_v    <= landRes.v;
      out_valid <= 1'b1;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops plus
// hand sequences for multiply latency, backpressure and reset during multiply.
module tb_alu_seq;

  logic       clk, rst, inValid, inReady, outValid, outReady;
  logic [2:0] mode;
  logic [7:0] reg1, reg2, dOut;
  logic       fz, fc, fn, fv;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .mode(mode), .reg1(reg1), .reg2(reg2),
    .out_valid(outValid), .out_ready(outReady), .out(dOut),
    .flag_z(fz), .flag_c(fc), .flag_n(fn), .flag_v(fv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] a, b, expOut;
    logic [3:0] expFlags;  // {Z,C,N,V}
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (inReady !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_in_ready", inReady, 1);
  endtask

  task automatic runMul(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expOut, input logic [3:0] expFlags, input string name);
    bit busyOk = 1;
    waitReady();
    inValid = 1; mode = 3'd7; reg1 = a; reg2 = b;
    tick();
    // operand changes after accept must not matter
    inValid = 0; mode = 3'd0; reg1 = 8'hFF; reg2 = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      if (inReady !== 1'b0 || outValid !== 1'b0) busyOk = 0;
      tick();
    end
    chk({name, "_busy8"}, busyOk, 1);
    chk({name, "_valid"}, outValid, 1);
    chk({name, "_out"}, dOut, expOut);
    chk({name, "_flags"}, {fz, fc, fn, fv}, expFlags);
    tick();
    chk({name, "_retired"}, outValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable, sawValid;

    vq.push_back('{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100, "add_ff_01"});
    vq.push_back('{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, "sub_80_01"});
    vq.push_back('{3'd1, 8'h01, 8'h02, 8'hFF, 4'b0110, "sub_01_02"});
    vq.push_back('{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011, "add_7f_01"});
    vq.push_back('{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, "and"});
    vq.push_back('{3'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0010, "or"});
    vq.push_back('{3'd4, 8'h55, 8'hAA, 8'hAA, 4'b0010, "not"});
    vq.push_back('{3'd5, 8'hAA, 8'hAA, 8'h00, 4'b1000, "xor_zero"});
    vq.push_back('{3'd6, 8'h81, 8'h09, 8'h02, 4'b0100, "shl_s1"});
    vq.push_back('{3'd6, 8'h81, 8'h00, 8'h81, 4'b0010, "shl_s0"});
    vq.push_back('{3'd6, 8'h03, 8'h07, 8'h80, 4'b0110, "shl_s7"});
    vq.push_back('{3'd6, 8'h01, 8'h04, 8'h10, 4'b0000, "shl_s4"});
    vq.push_back('{3'd0, 8'h02, 8'h03, 8'h05, 4'b0000, "add_2_3"});
    vq.push_back('{3'd1, 8'h05, 8'h05, 8'h00, 4'b1000, "sub_eq"});

    rst = 1; inValid = 0; mode = 0; reg1 = 0; reg2 = 0; outReady = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", dOut, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_flags", {fz, fc, fn, fv}, 0);
    chk("rst_in_ready", inReady, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", inReady, 1);

    // back-to-back single-cycle ops, one result per cycle
    foreach (vq[i]) begin
      chk({vq[i].name, "_in_ready"}, inReady, 1);
      inValid = 1; mode = vq[i].mode; reg1 = vq[i].a; reg2 = vq[i].b;
      tick();
      chk({vq[i].name, "_valid"}, outValid, 1);
      chk({vq[i].name, "_out"}, dOut, vq[i].expOut);
      chk({vq[i].name, "_flags"}, {fz, fc, fn, fv}, vq[i].expFlags);
    end
    inValid = 0;
    tick();
    chk("table_retire", outValid, 0);

    runMul(8'h10, 8'h11, 8'h10, 4'b0100, "mul_10_11");
    runMul(8'hFF, 8'hFF, 8'h01, 4'b0100, "mul_ff_ff");
    runMul(8'h0F, 8'h03, 8'h2D, 4'b0000, "mul_0f_03");
    runMul(8'h80, 8'h02, 8'h00, 4'b1100, "mul_80_02");

    // backpressure: result held, further requests ignored
    waitReady();
    outReady = 0; inValid = 1; mode = 3'd5; reg1 = 8'h3C; reg2 = 8'h0F;
    tick();
    mode = 3'd0; reg1 = 8'hFF; reg2 = 8'hFF;
    stable = 1;
    for (int k = 0; k < 5; k++) begin
      if (outValid !== 1'b1 || dOut !== 8'h33 || {fz, fc, fn, fv} !== 4'b0000 || inReady !== 1'b0)
        stable = 0;
      tick();
    end
    chk("bp_stable", stable, 1);
    inValid = 0; outReady = 1;
    chk("bp_out_before_retire", dOut, 8'h33);
    tick();
    chk("bp_retired", outValid, 0);
    chk("bp_out_held", dOut, 8'h33);
    tick();
    chk("bp_no_ghost", outValid, 0);

    // reset three cycles into a multiply
    waitReady();
    inValid = 1; mode = 3'd7; reg1 = 8'h10; reg2 = 8'h11;
    tick();
    inValid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("midmul_rst_in_ready", inReady, 0);
    tick();
    rst = 0;
    chk("midmul_rst_out", dOut, 0);
    chk("midmul_rst_valid", outValid, 0);
    chk("midmul_rst_flags", {fz, fc, fn, fv}, 0);
    #1;
    chk("midmul_in_ready", inReady, 1);
    sawValid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (outValid !== 1'b0) sawValid = 1;
    end
    chk("midmul_no_result", sawValid, 0);
    inValid = 1; mode = 3'd0; reg1 = 8'h02; reg2 = 8'h03;
    tick();
    inValid = 0;
    chk("after_rst_add_valid", outValid, 1);
    chk("after_rst_add_out", dOut, 8'h05);
    chk("after_rst_add_flags", {fz, fc, fn, fv}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
